dmem_arb: RTL and testbench

- Two-requester arbiter that shares the single-port data memory between the CPU load/store port (port 0) and a debug/DMA port (port 1).
- Grants at most one access per cycle and drives the memory's clk-domain write-enable, address and write-data pins.
- Returns read data registered one cycle after grant.
- Round-robin by default; supports a per-port lock for atomic multi-cycle sequences such as read-modify-write.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/rr_pick2.sv | 27 ++
 rtl/dmem_arb.sv | 116 +++++++++++
 tb/tb_dmem_arb.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    // Lock ownership of the shared memory port
    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Requester indices, also the encoding of last_gnt
    localparam logic P_CPU = 1'b0;
    localparam logic P_DBG = 1'b1;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way picker; round-robin or fixed priority,
//                one-hot winner output.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import dmem_arb_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_gnt,
    output logic [1:0] win
);

    // Port 0 wins alone, under fixed priority, or when port 1 won last time
    always_comb begin
        win    = 2'b00;
        win[0] = req0 & (~req1 | (FIXED_PRI != 0) | (last_gnt == P_DBG));
        win[1] = req1 & ~win[0];
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/dmem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb
//  Description : Two-port arbiter for a single-port data memory with per-port
//                lock for atomic multi-cycle sequences and registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [DWIDTH-1:0] a0,
    input  logic [DWIDTH-1:0] a1,
    input  logic [DWIDTH-1:0] wd0,
    input  logic [DWIDTH-1:0] wd1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] rdata,
    output logic              mem_we,
    output logic [DWIDTH-1:0] mem_a,
    output logic [DWIDTH-1:0] mem_wd,
    input  logic [DWIDTH-1:0] mem_rd
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_gnt;
    logic       w_elig0;
    logic       w_elig1;
    logic [1:0] w_win;

    // A held lock hides the other port's request from the picker
    always_comb begin
        w_elig0 = req0 & (r_state != OWN1);
        w_elig1 = req1 & (r_state != OWN0);
    end

    rr_pick2 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_pick (
        .req0     (w_elig0),
        .req1     (w_elig1),
        .last_gnt (r_last_gnt),
        .win      (w_win)
    );

    // Grants (forced low during reset) and lock next-state
    always_comb begin
        gnt0        = w_win[0] & rst_n;
        gnt1        = w_win[1] & rst_n;
        w_state_nxt = r_state;
        case (r_state)
            FREE: begin
                if (gnt0 && lock0)      w_state_nxt = OWN0;
                else if (gnt1 && lock1) w_state_nxt = OWN1;
            end
            OWN0: begin
                if (!lock0 && (gnt0 || !req0)) w_state_nxt = FREE;
            end
            OWN1: begin
                if (!lock1 && (gnt1 || !req1)) w_state_nxt = FREE;
            end
            default: w_state_nxt = FREE;
        endcase
    end

    // Route the granted port to the memory pins; port 0 values when idle
    always_comb begin
        mem_we = 1'b0;
        mem_a  = a0;
        mem_wd = wd0;
        if (gnt1) begin
            mem_we = we1;
            mem_a  = a1;
            mem_wd = wd1;
        end else if (gnt0) begin
            mem_we = we0;
        end
    end

    // Lock state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FREE;
        else        r_state <= w_state_nxt;
    end

    // Round-robin history, read-data capture and per-port read-valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= P_DBG;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata      <= '0;
        end else begin
            if (gnt0)      r_last_gnt <= P_CPU;
            else if (gnt1) r_last_gnt <= P_DBG;
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if ((gnt0 && !we0) || (gnt1 && !we1)) rdata <= mem_rd;
        end
    end

endmodule : dmem_arb
`default_nettype wire

// File: tb/tb_dmem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arb
//  Description : Directed self-checking bench for dmem_arb (round-robin and
//                fixed-priority instances sharing stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arb;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
    logic [7:0] a0 = 0, a1 = 0, wd0 = 0, wd1 = 0;

    logic       gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [7:0] rdata, mem_a, mem_wd, mem_rd;
    logic       fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_mem_we;
    logic [7:0] fp_rdata, fp_mem_a, fp_mem_wd, fp_mem_rd;

    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural memory: preload under reset, writes from the round-robin DUT
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[8'h10] <= 8'hA5;
            mem[8'h20] <= 8'h03;
            mem[8'h30] <= 8'h11;
            mem[8'h31] <= 8'h22;
            mem[8'h40] <= 8'h77;
        end else if (mem_we) begin
            mem[mem_a] <= mem_wd;
        end
    end

    assign mem_rd    = mem[mem_a];
    assign fp_mem_rd = mem[fp_mem_a];

    dmem_arb #(.DWIDTH(8), .FIXED_PRI(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    dmem_arb #(.DWIDTH(8), .FIXED_PRI(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1),
        .rdata(fp_rdata), .mem_we(fp_mem_we), .mem_a(fp_mem_a), .mem_wd(fp_mem_wd),
        .mem_rd(fp_mem_rd)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        req0 = 1'b1;
        #1;
        check("rst_gnt0", {7'd0, gnt0}, 8'd0);
        check("rst_gnt1", {7'd0, gnt1}, 8'd0);
        check("rst_mem_we", {7'd0, mem_we}, 8'd0);
        check("rst_rvalid0", {7'd0, rvalid0}, 8'd0);
        check("rst_rvalid1", {7'd0, rvalid1}, 8'd0);
        check("rst_rdata", rdata, 8'h00);
        req0 = 1'b0;
        step();
        step();
        #2 rst_n = 1'b1;
        step();

        // ---------------- contention: RR vs fixed priority ----------------
        req0 = 1; we0 = 0; a0 = 8'h30;
        req1 = 1; we1 = 0; a1 = 8'h31;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_gnt0_%0d", i), {7'd0, gnt0}, (i % 2 == 0) ? 8'd1 : 8'd0);
            check($sformatf("rr_gnt1_%0d", i), {7'd0, gnt1}, (i % 2 == 0) ? 8'd0 : 8'd1);
            check($sformatf("fp_gnt0_%0d", i), {7'd0, fp_gnt0}, 8'd1);
            check($sformatf("fp_gnt1_%0d", i), {7'd0, fp_gnt1}, 8'd0);
            step();
            check($sformatf("rr_rvalid0_%0d", i), {7'd0, rvalid0}, (i % 2 == 0) ? 8'd1 : 8'd0);
            check($sformatf("rr_rvalid1_%0d", i), {7'd0, rvalid1}, (i % 2 == 0) ? 8'd0 : 8'd1);
            check($sformatf("rr_rdata_%0d", i), rdata, (i % 2 == 0) ? 8'h11 : 8'h22);
            check($sformatf("fp_rvalid0_%0d", i), {7'd0, fp_rvalid0}, 8'd1);
        end
        req0 = 0;
        #1;
        check("fp_gnt1_after_drop", {7'd0, fp_gnt1}, 8'd1);
        step();
        check("fp_rvalid1_after_drop", {7'd0, fp_rvalid1}, 8'd1);
        check("fp_rdata_after_drop", fp_rdata, 8'h22);
        req1 = 0;
        step();

        // ---------------- single read ----------------
        req0 = 1; we0 = 0; a0 = 8'h10;
        #1;
        check("sr_gnt0", {7'd0, gnt0}, 8'd1);
        check("sr_mem_we", {7'd0, mem_we}, 8'd0);
        check("sr_mem_a", mem_a, 8'h10);
        step();
        req0 = 0;
        check("sr_rvalid0", {7'd0, rvalid0}, 8'd1);
        check("sr_rdata", rdata, 8'hA5);
        check("sr_rvalid1", {7'd0, rvalid1}, 8'd0);
        step();

        // ---------------- lock / read-modify-write by port 1 ----------------
        req0 = 1; we0 = 0; a0 = 8'h40;
        req1 = 1; we1 = 0; a1 = 8'h20; lock1 = 1;
        #1;
        check("rmw_rd_gnt1", {7'd0, gnt1}, 8'd1);
        check("rmw_rd_gnt0", {7'd0, gnt0}, 8'd0);
        step();
        check("rmw_rvalid1", {7'd0, rvalid1}, 8'd1);
        check("rmw_rdata", rdata, 8'h03);
        we1 = 1; wd1 = 8'h04; lock1 = 0;
        #1;
        check("rmw_wr_gnt1", {7'd0, gnt1}, 8'd1);
        check("rmw_wr_gnt0", {7'd0, gnt0}, 8'd0);
        check("rmw_mem_we", {7'd0, mem_we}, 8'd1);
        check("rmw_mem_wd", mem_wd, 8'h04);
        check("rmw_mem_a", mem_a, 8'h20);
        step();
        req1 = 0; we1 = 0;
        check("rmw_wr_no_rvalid", {7'd0, rvalid1}, 8'd0);
        a0 = 8'h20;
        #1;
        check("rmw_after_gnt0", {7'd0, gnt0}, 8'd1);
        step();
        req0 = 0;
        check("rmw_readback_rvalid0", {7'd0, rvalid0}, 8'd1);
        check("rmw_readback_rdata", rdata, 8'h04);
        step();

        // ---------------- reset mid-lock ----------------
        req0 = 1; we0 = 0; a0 = 8'h10; lock0 = 1;
        #1;
        check("ml_gnt0", {7'd0, gnt0}, 8'd1);
        step();
        req1 = 1; we1 = 0; a1 = 8'h30;
        #1;
        check("ml_stall_gnt1", {7'd0, gnt1}, 8'd0);
        check("ml_own_gnt0", {7'd0, gnt0}, 8'd1);
        check("ml_rvalid0_before", {7'd0, rvalid0}, 8'd1);
        rst_n = 0;
        #1;
        check("ml_rst_gnt0", {7'd0, gnt0}, 8'd0);
        check("ml_rst_gnt1", {7'd0, gnt1}, 8'd0);
        check("ml_rst_rvalid0", {7'd0, rvalid0}, 8'd0);
        rst_n = 1;
        req0 = 0; lock0 = 0;
        #1;
        check("ml_post_gnt1", {7'd0, gnt1}, 8'd1);
        step();
        req1 = 0;
        check("ml_post_rvalid1", {7'd0, rvalid1}, 8'd1);
        check("ml_post_rdata", rdata, 8'h11);
        step();

        // ---------------- write then read same address ----------------
        req0 = 1; we0 = 1; a0 = 8'h08; wd0 = 8'h5A;
        #1;
        check("wr_mem_we", {7'd0, mem_we}, 8'd1);
        check("wr_mem_wd", mem_wd, 8'h5A);
        step();
        check("wr_no_rvalid0", {7'd0, rvalid0}, 8'd0);
        we0 = 0;
        #1;
        check("raw_gnt0", {7'd0, gnt0}, 8'd1);
        check("raw_mem_we", {7'd0, mem_we}, 8'd0);
        step();
        req0 = 0;
        check("raw_rvalid0", {7'd0, rvalid0}, 8'd1);
        check("raw_rdata", rdata, 8'h5A);
        step();
        check("idle_rvalid0", {7'd0, rvalid0}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dmem_arb
`default_nettype wire
